board_write_sched: RTL and testbench

Sequencer and arbiter for the single write port of the 32×24 board RAM. Pac-Man and ghost movers each raise a move request carrying an old cell, a new cell and a sprite tile code. The block grants one requester at a time and issues a two-write sequence to the RAM: clear the old cell, then draw the new cell. It replaces the ad-hoc write FSM in the top level and runs on the same slow game clock.

---
 rtl/board_pkg.sv | 23 ++
 rtl/board_write_sched_if.sv | 33 +++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/board_write_sched.sv | 161 ++++++++++++++++
 tb/tb_board_write_sched.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/board_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | board_pkg : board geometry, tile codes and write-scheduler state encoding  |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
package board_pkg;

    localparam int BOARD_W     = 32;
    localparam int BOARD_H     = 24;
    localparam int BOARD_CELLS = BOARD_W * BOARD_H;

    localparam logic [3:0] TILE_EMPTY = 4'd0;
    localparam logic [3:0] TILE_PAC   = 4'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DRAW  = 2'd2,
        S_ACK   = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/board_write_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | board_write_sched_if : mover requests in, board RAM write port out         |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface board_write_sched_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4
) ();

    logic [N_REQ-1:0]             req;
    logic [N_REQ-1:0][ADDR_W-1:0] old_addr;
    logic [N_REQ-1:0][ADDR_W-1:0] new_addr;
    logic [N_REQ-1:0][DATA_W-1:0] tile;
    logic [N_REQ-1:0]             done;
    logic                         busy;
    logic                         wren;
    logic [ADDR_W-1:0]            write_addr;
    logic [DATA_W-1:0]            write_data;

    modport master (
        output req, old_addr, new_addr, tile,
        input  done, busy, wren, write_addr, write_data
    );

    modport slave (
        input  req, old_addr, new_addr, tile,
        output done, busy, wren, write_addr, write_data
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter : rotating-priority arbiter, first request at or after i_ptr    |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  wire logic [N_REQ-1:0] i_req,
    input  wire logic [IDX_W-1:0] i_ptr,
    output logic      [N_REQ-1:0] o_grant,
    output logic      [IDX_W-1:0] o_idx,
    output logic                  o_valid
);

    localparam logic [IDX_W:0] c_n = (IDX_W+1)'(N_REQ);

    logic [IDX_W-1:0] w_cand [N_REQ];

    // Candidate i is the i-th requester in priority order, wrapped modulo N_REQ.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
        logic [IDX_W:0] w_sum;
        assign w_sum       = {1'b0, i_ptr} + (IDX_W+1)'(gi);
        assign w_cand[gi]  = (w_sum >= c_n) ? IDX_W'(w_sum - c_n) : IDX_W'(w_sum);
    end

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!o_valid && i_req[w_cand[i]]) begin
                o_valid            = 1'b1;
                o_idx              = w_cand[i];
                o_grant[w_cand[i]] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/board_write_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | board_write_sched : arbitrates mover requests, issues clear/draw writes    |
// | Option    : ROUND_ROBIN_EN (rotating priority; fixed priority otherwise)   |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module board_write_sched
    import board_pkg::*;
#(
    parameter int                N_REQ   = 4,
    parameter int                ADDR_W  = 10,
    parameter int                DATA_W  = 4,
    parameter logic [DATA_W-1:0] BG_TILE = '0
) (
    input wire logic          clk,
    input wire logic          reset,
    board_write_sched_if.slave bus
);

    localparam int             IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [ADDR_W:0] c_cells = (ADDR_W+1)'(BOARD_CELLS);

    sched_state_t      r_state, w_next;
    logic [ADDR_W-1:0] r_old, r_new;
    logic [DATA_W-1:0] r_tile;
    logic [N_REQ-1:0]  r_grant;

    logic [N_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]  w_idx;
    logic              w_valid;
    logic [IDX_W-1:0]  w_ptr;

    logic              w_wren, w_busy;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [N_REQ-1:0]  w_done;

    logic              r_wren, r_busy;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [N_REQ-1:0]  r_done;

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .i_req   (bus.req),
        .i_ptr   (w_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

`ifdef ROUND_ROBIN_EN
    localparam logic [IDX_W-1:0] c_last = IDX_W'(N_REQ - 1);

    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
            r_ptr <= '0;
        end else begin
            if (r_state == S_IDLE && w_valid) begin
                r_idx <= w_idx;
            end
            if (r_state == S_ACK) begin
                r_ptr <= (r_idx == c_last) ? '0 : IDX_W'(r_idx + 1'b1);
            end
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_valid) w_next = S_CLEAR;
            S_CLEAR: w_next = S_DRAW;
            S_DRAW:  w_next = S_ACK;
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request fields are captured once at grant; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_old   <= '0;
            r_new   <= '0;
            r_tile  <= '0;
            r_grant <= '0;
        end else if (r_state == S_IDLE && w_valid) begin
            r_old   <= bus.old_addr[w_idx];
            r_new   <= bus.new_addr[w_idx];
            r_tile  <= bus.tile[w_idx];
            r_grant <= w_grant;
        end
    end

    always_comb begin
        w_wren = 1'b0;
        w_busy = 1'b0;
        w_addr = '0;
        w_data = '0;
        w_done = '0;
        case (r_state)
            S_CLEAR: begin
                w_busy = 1'b1;
                w_wren = ({1'b0, r_old} < c_cells);
                w_addr = r_old;
                w_data = BG_TILE;
            end
            S_DRAW: begin
                w_busy = 1'b1;
                w_wren = ({1'b0, r_new} < c_cells);
                w_addr = r_new;
                w_data = r_tile;
            end
            S_ACK: begin
                w_busy = 1'b1;
                w_done = r_grant;
            end
            default: ;
        endcase
    end

    // Outputs trail the state register by one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wren <= 1'b0;
            r_busy <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_done <= '0;
        end else begin
            r_wren <= w_wren;
            r_busy <= w_busy;
            r_addr <= w_addr;
            r_data <= w_data;
            r_done <= w_done;
        end
    end

    assign bus.wren       = r_wren;
    assign bus.busy       = r_busy;
    assign bus.write_addr = r_addr;
    assign bus.write_data = r_data;
    assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_board_write_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_board_write_sched : directed + random stimulus against a schedule model |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module tb_board_write_sched;

    localparam int N     = 4;
    localparam int AW    = 10;
    localparam int DW    = 4;
    localparam int CELLS = 32 * 24;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    board_write_sched_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    board_write_sched #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BG_TILE(4'b0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Expected outputs per edge, ring-indexed by edge number.
    logic          e_wren [8];
    logic          e_busy [8];
    logic [AW-1:0] e_addr [8];
    logic [DW-1:0] e_data [8];
    logic [N-1:0]  e_done [8];
    int            m_free_at = 0;
`ifdef ROUND_ROBIN_EN
    int            m_ptr = 0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_slots();
        for (int s = 0; s < 8; s++) begin
            e_wren[s] = 1'b0; e_busy[s] = 1'b0;
            e_addr[s] = '0;   e_data[s] = '0; e_done[s] = '0;
        end
    endtask

    // Winner is the first requester scanning upward from base, modulo N.
    function automatic int pick(input logic [N-1:0] r, input int base);
        for (int k = 0; k < N; k++) begin
            if (r[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    // Called with the inputs that the coming edge e will sample.
    task automatic model_edge(input int e);
        int w;
        int s;
        if (reset) begin
            clear_slots();
            m_free_at = e + 1;
`ifdef ROUND_ROBIN_EN
            m_ptr = 0;
`endif
        end else if (e >= m_free_at) begin
`ifdef ROUND_ROBIN_EN
            w = pick(bus.req, m_ptr);
`else
            w = pick(bus.req, 0);
`endif
            if (w >= 0) begin
                s = (e + 1) % 8;
                e_busy[s] = 1'b1;
                e_wren[s] = (int'(bus.old_addr[w]) < CELLS);
                e_addr[s] = bus.old_addr[w];
                e_data[s] = 4'b0000;
                s = (e + 2) % 8;
                e_busy[s] = 1'b1;
                e_wren[s] = (int'(bus.new_addr[w]) < CELLS);
                e_addr[s] = bus.new_addr[w];
                e_data[s] = bus.tile[w];
                s = (e + 3) % 8;
                e_busy[s] = 1'b1;
                e_done[s] = N'(1) << w;
                m_free_at = e + 4;
`ifdef ROUND_ROBIN_EN
                m_ptr = (w + 1) % N;
`endif
            end
        end
    endtask

    // One clock: predict, take the edge, compare just after it, return at negedge.
    task automatic tick();
        int s;
        model_edge(cyc + 1);
        @(posedge clk);
        cyc++;
        #1;
        s = cyc % 8;
        check("wren", 64'(bus.wren), 64'(e_wren[s]));
        check("busy", 64'(bus.busy), 64'(e_busy[s]));
        check("addr", 64'(bus.write_addr), 64'(e_addr[s]));
        check("data", 64'(bus.write_data), 64'(e_data[s]));
        check("done", 64'(bus.done), 64'(e_done[s]));
        e_wren[s] = 1'b0; e_busy[s] = 1'b0;
        e_addr[s] = '0;   e_data[s] = '0; e_done[s] = '0;
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input int oa, input int na, input int t);
        bus.old_addr[i] = AW'(oa);
        bus.new_addr[i] = AW'(na);
        bus.tile[i]     = DW'(t);
        bus.req[i]      = 1'b1;
    endtask

    task automatic idle_ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        clear_slots();
        reset        = 1'b1;
        bus.req      = '0;
        bus.old_addr = '0;
        bus.new_addr = '0;
        bus.tile     = '0;
        @(negedge clk);
        idle_ticks(3);
        reset = 1'b0;
        idle_ticks(2);

        // Single request from Pac-Man.
        set_req(0, 495, 496, 3);
        idle_ticks(4);
        bus.req = '0;
        idle_ticks(2);

        // Out-of-range old cell.
        set_req(0, 800, 10, 5);
        idle_ticks(4);
        bus.req = '0;
        idle_ticks(2);

        // Full contention.
        set_req(0, 100, 101, 3);
        set_req(1, 200, 201, 6);
        set_req(2, 300, 301, 7);
        set_req(3, 400, 400, 8);
        idle_ticks(20);
        bus.req = '0;
        idle_ticks(4);

        // Two-way contention.
        set_req(0, 1, 2, 3);
        set_req(1, 3, 4, 9);
        idle_ticks(12);
        bus.req = '0;
        idle_ticks(4);

        // Reset while the draw step is in flight, then a fresh ghost request.
        set_req(1, 50, 51, 4);
        idle_ticks(2);
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        bus.req = '0;
        set_req(2, 60, 61, 2);
        idle_ticks(4);
        bus.req = '0;
        idle_ticks(2);

        // Early drop right after grant, with fields changing mid-sequence.
        set_req(1, 70, 71, 12);
        tick();
        bus.req         = '0;
        bus.old_addr[1] = AW'(5);
        bus.tile[1]     = DW'(1);
        idle_ticks(5);

        // Randomised traffic.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req[i]) begin
                    if ($urandom_range(3, 0) == 0) begin
                        bus.old_addr[i] = AW'($urandom_range(1023, 0));
                        bus.new_addr[i] = ($urandom_range(7, 0) == 0) ? bus.old_addr[i]
                                                                      : AW'($urandom_range(1023, 0));
                        bus.tile[i]     = DW'($urandom_range(15, 0));
                        bus.req[i]      = 1'b1;
                    end
                end else if ((bus.done[i] && $urandom_range(3, 0) != 0) ||
                             $urandom_range(15, 0) == 0) begin
                    bus.req[i] = 1'b0;
                end else if ($urandom_range(7, 0) == 0) begin
                    bus.new_addr[i] = AW'($urandom_range(1023, 0));
                end
            end
            reset = ($urandom_range(299, 0) == 0);
            tick();
        end
        reset   = 1'b0;
        bus.req = '0;
        idle_ticks(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
